// File: rtl/load_store_unit.sv
// load_store_unit: sequences byte/halfword load-store requests into byte accesses on DataMem.
// Optional macro LSU_WRAP_FAULT_EN: a wide access at the top address faults instead of wrapping.
module load_store_unit #(
    parameter int DATA_PATH_WIDTH = 8,
    parameter int ADDR_WIDTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_wen,
    input  logic                         req_wide,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [2*DATA_PATH_WIDTH-1:0] req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [2*DATA_PATH_WIDTH-1:0] rsp_rdata,
    output logic                         rsp_fault,
    output logic                         mem_wen,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [DATA_PATH_WIDTH-1:0]   mem_data_in,
    input  logic [DATA_PATH_WIDTH-1:0]   mem_data_out
);
    localparam int DW = DATA_PATH_WIDTH;
    localparam int AW = ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t          state, state_nx;
    logic            wen_q, wide_q, fault_q, wrap_fault, accept;
    logic [AW-1:0]   addr_q;
    logic [2*DW-1:0] wdata_q, rdata_q;

`ifdef LSU_WRAP_FAULT_EN
    assign wrap_fault = req_wide && (&req_addr);
`else
    assign wrap_fault = 1'b0;
`endif

    assign accept    = (state == IDLE) && req_valid;
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;

    // next state and DataMem drive, all decoded from the current state
    always_comb begin
        state_nx    = state;
        mem_wen     = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        case (state)
            IDLE: state_nx = req_valid ? (wrap_fault ? RESP : ACC0) : IDLE;
            ACC0: begin
                state_nx    = wide_q ? ACC1 : RESP;
                mem_wen     = wen_q;
                mem_addr    = addr_q;
                mem_data_in = wen_q ? wdata_q[DW-1:0] : '0;
            end
            ACC1: begin
                state_nx    = RESP;
                mem_wen     = wen_q;
                mem_addr    = addr_q + AW'(1);
                mem_data_in = wen_q ? wdata_q[2*DW-1:DW] : '0;
            end
            RESP: state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // request latch on accept, load data capture during the byte accesses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q   <= 1'b0;
            wide_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else if (accept) begin
            wen_q   <= req_wen;
            wide_q  <= req_wide;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            fault_q <= wrap_fault;
        end else if (state == ACC0 && !wen_q) begin
            rdata_q[DW-1:0] <= mem_data_out;
        end else if (state == ACC1 && !wen_q) begin
            rdata_q[2*DW-1:DW] <= mem_data_out;
        end
    end
endmodule
